// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared defaults, op code type and FSM states for the ALU sequencer
package alu_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int NREGS_DEF  = 8;

    typedef logic [1:0] alu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WB   = 2'd2
    } seq_state_t;

endpackage

// File: rtl/alu_sequencer_if.sv
// rtl/alu_sequencer_if.sv - preload, command, ALU, writeback and debug signals of the sequencer
interface alu_sequencer_if import alu_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int AW     = $clog2(NREGS_DEF)
);

    logic              ld_valid;
    logic [AW-1:0]     ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready;

    logic              cmd_valid;
    alu_op_t           cmd_op;
    logic [AW-1:0]     cmd_rd;
    logic [AW-1:0]     cmd_rs1;
    logic [AW-1:0]     cmd_rs2;
    logic              cmd_ready;

    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    alu_op_t           alu_c;
    logic [DATA_W-1:0] alu_out;

    logic              res_valid;
    logic [AW-1:0]     res_rd;
    logic [DATA_W-1:0] res_data;

    logic [AW-1:0]     dbg_addr;
    logic [DATA_W-1:0] dbg_data;

    modport master (
        output ld_valid, ld_addr, ld_data,
        input  ld_ready,
        output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2,
        input  cmd_ready,
        input  alu_a, alu_b, alu_c,
        output alu_out,
        input  res_valid, res_rd, res_data,
        output dbg_addr,
        input  dbg_data
    );

    modport slave (
        input  ld_valid, ld_addr, ld_data,
        output ld_ready,
        input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2,
        output cmd_ready,
        output alu_a, alu_b, alu_c,
        input  alu_out,
        output res_valid, res_rd, res_data,
        input  dbg_addr,
        output dbg_data
    );

endinterface

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - register file with two operand read ports, a debug read tap and one write port
module alu_regfile #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 8,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     ra1,
    output logic [DATA_W-1:0] rd1,
    input  logic [AW-1:0]     ra2,
    output logic [DATA_W-1:0] rd2,
    input  logic [AW-1:0]     dbg_ra,
    output logic [DATA_W-1:0] dbg_rd
);

    logic [DATA_W-1:0] rf [NREGS];

    // Single write port; the sequencer decides who owns it each cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else if (we) begin
            rf[waddr] <= wdata;
        end
    end

    assign rd1    = rf[ra1];
    assign rd2    = rf[ra2];
    assign dbg_rd = rf[dbg_ra];

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - IDLE/EXEC/WB sequencer feeding an external ALU; ALU_SEQ_R0_ZERO_EN pins r0 to zero
module alu_sequencer import alu_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int NREGS  = NREGS_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_sequencer_if.slave bus
);

    localparam int AW = $clog2(NREGS);

    seq_state_t        state_q, state_d;
    logic [AW-1:0]     rd_q;
    logic              ld_fire, cmd_fire;
    logic              rf_we;
    logic [AW-1:0]     rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [DATA_W-1:0] rs1_data, rs2_data;

    // Preload wins over a command presented in the same IDLE cycle.
    assign ld_fire  = bus.ld_valid && (state_q == IDLE);
    assign cmd_fire = bus.cmd_valid && (state_q == IDLE) && !bus.ld_valid;

    // State register; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_d       = state_q;
        bus.ld_ready  = 1'b0;
        bus.cmd_ready = 1'b0;
        bus.res_valid = 1'b0;
        case (state_q)
            IDLE: begin
                bus.ld_ready  = 1'b1;
                bus.cmd_ready = !bus.ld_valid;
                if (cmd_fire) state_d = EXEC;
            end
            EXEC: state_d = WB;
            WB: begin
                bus.res_valid = 1'b1;
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand/op latch at accept and result capture in EXEC; all hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.alu_a    <= '0;
            bus.alu_b    <= '0;
            bus.alu_c    <= '0;
            bus.res_data <= '0;
            rd_q         <= '0;
        end else begin
            if (cmd_fire) begin
                bus.alu_a <= rs1_data;
                bus.alu_b <= rs2_data;
                bus.alu_c <= bus.cmd_op;
                rd_q      <= bus.cmd_rd;
            end
            if (state_q == EXEC) bus.res_data <= bus.alu_out;
        end
    end

    assign bus.res_rd = rd_q;

    // Write-port arbitration: preloads only happen in IDLE, writebacks only in WB.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = rd_q;
        rf_wdata = bus.res_data;
        if (ld_fire) begin
            rf_we    = 1'b1;
            rf_waddr = bus.ld_addr;
            rf_wdata = bus.ld_data;
        end else if (state_q == WB) begin
            rf_we = 1'b1;
        end
`ifdef ALU_SEQ_R0_ZERO_EN
        if (rf_waddr == '0) rf_we = 1'b0;
`else
        rf_we = rf_we;
`endif
    end

    alu_regfile #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .AW     (AW)
    ) u_regfile (
        .clk    (clk),
        .rst_n  (rst_n),
        .we     (rf_we),
        .waddr  (rf_waddr),
        .wdata  (rf_wdata),
        .ra1    (bus.cmd_rs1),
        .rd1    (rs1_data),
        .ra2    (bus.cmd_rs2),
        .rd2    (rs2_data),
        .dbg_ra (bus.dbg_addr),
        .dbg_rd (bus.dbg_data)
    );

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - directed self-checking bench for alu_sequencer with an adder stub ALU
module tb_alu_sequencer;
    import alu_pkg::*;

    localparam int DATA_W = 32;
    localparam int NREGS  = 8;
    localparam int AW     = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [DATA_W-1:0] r_data, r_a, r_b;
    logic [AW-1:0]     r_rd;
    int                r_lat;

    always #5 clk = ~clk;

    alu_sequencer_if #(.DATA_W(DATA_W), .AW(AW)) bus ();

    assign bus.alu_out = bus.alu_a + bus.alu_b;

    alu_sequencer #(.DATA_W(DATA_W), .NREGS(NREGS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    task automatic preload(input logic [AW-1:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        bus.ld_valid = 1'b1; bus.ld_addr = a; bus.ld_data = d;
        @(negedge clk);
        bus.ld_valid = 1'b0;
    endtask

    task automatic run_cmd(input alu_op_t op, input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                           input logic [AW-1:0] rs2, output logic [DATA_W-1:0] data,
                           output logic [AW-1:0] rrd, output logic [DATA_W-1:0] a,
                           output logic [DATA_W-1:0] b, output int lat);
        int waited;
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_rd = rd; bus.cmd_rs1 = rs1; bus.cmd_rs2 = rs2;
        #1;
        waited = 0;
        while (!bus.cmd_ready && waited < 10) begin @(negedge clk); #1; waited++; end
        n_cmp++;
        if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL run_cmd_accept: cmd_ready=%b want 1", bus.cmd_ready); end
        @(negedge clk); bus.cmd_valid = 1'b0; #1;
        lat = 1;
        while (!bus.res_valid && lat < 6) begin @(negedge clk); #1; lat++; end
        n_cmp++;
        if (bus.res_valid !== 1'b1) begin n_err++; $display("FAIL run_cmd_result: res_valid=%b want 1", bus.res_valid); end
        data = bus.res_data; rrd = bus.res_rd; a = bus.alu_a; b = bus.alu_b;
    endtask

    task automatic test_reset;
        @(negedge clk); #1;
        n_cmp++; if (bus.ld_ready !== 1'b1)  begin n_err++; $display("FAIL rst_ld_ready: got %b want 1", bus.ld_ready); end
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_cmd_ready: got %b want 1", bus.cmd_ready); end
        n_cmp++; if (bus.res_valid !== 1'b0) begin n_err++; $display("FAIL rst_res_valid: got %b want 0", bus.res_valid); end
        n_cmp++; if (bus.alu_a !== '0 || bus.alu_b !== '0 || bus.alu_c !== 2'b00)
            begin n_err++; $display("FAIL rst_alu: got a=%0d b=%0d c=%0d want 0", bus.alu_a, bus.alu_b, bus.alu_c); end
        n_cmp++; if (bus.res_data !== '0 || bus.res_rd !== '0)
            begin n_err++; $display("FAIL rst_res: got data=%0d rd=%0d want 0", bus.res_data, bus.res_rd); end
        for (int i = 0; i < NREGS; i++) begin
            bus.dbg_addr = AW'(i); #1;
            n_cmp++; if (bus.dbg_data !== '0) begin n_err++; $display("FAIL rst_rf%0d: got %0d want 0", i, bus.dbg_data); end
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_basic;
        preload(3'd1, 32'd5);
        preload(3'd2, 32'd6);
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b00; bus.cmd_rd = 3'd3; bus.cmd_rs1 = 3'd1; bus.cmd_rs2 = 3'd2; #1;
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL basic_accept: got %b want 1", bus.cmd_ready); end
        @(negedge clk); bus.cmd_valid = 1'b0; #1;
        n_cmp++; if (bus.alu_a !== 32'd5 || bus.alu_b !== 32'd6 || bus.alu_c !== 2'b00)
            begin n_err++; $display("FAIL basic_operands: got a=%0d b=%0d c=%0d want 5 6 0", bus.alu_a, bus.alu_b, bus.alu_c); end
        n_cmp++; if (bus.cmd_ready !== 1'b0 || bus.ld_ready !== 1'b0 || bus.res_valid !== 1'b0)
            begin n_err++; $display("FAIL basic_exec_flags: got cr=%b lr=%b rv=%b want 0 0 0", bus.cmd_ready, bus.ld_ready, bus.res_valid); end
        @(negedge clk); #1;
        n_cmp++; if (bus.res_valid !== 1'b1 || bus.res_data !== 32'd11 || bus.res_rd !== 3'd3)
            begin n_err++; $display("FAIL basic_wb: got rv=%b data=%0d rd=%0d want 1 11 3", bus.res_valid, bus.res_data, bus.res_rd); end
        n_cmp++; if (bus.alu_a !== 32'd5) begin n_err++; $display("FAIL basic_hold_a: got %0d want 5", bus.alu_a); end
        @(negedge clk); bus.dbg_addr = 3'd3; #1;
        n_cmp++; if (bus.res_valid !== 1'b0 || bus.cmd_ready !== 1'b1)
            begin n_err++; $display("FAIL basic_idle: got rv=%b cr=%b want 0 1", bus.res_valid, bus.cmd_ready); end
        n_cmp++; if (bus.dbg_data !== 32'd11 || bus.res_data !== 32'd11)
            begin n_err++; $display("FAIL basic_dbg: got dbg=%0d res=%0d want 11 11", bus.dbg_data, bus.res_data); end
    endtask

    task automatic test_back_to_back;
        int pulses;
        pulses = 0;
        preload(3'd4, 32'd8);
        preload(3'd5, 32'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b1; bus.cmd_op = 2'(k); bus.cmd_rd = 3'd7; bus.cmd_rs1 = 3'd4; bus.cmd_rs2 = 3'd5; #1;
            n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL b2b_accept%0d: got %b want 1", k, bus.cmd_ready); end
            @(negedge clk);
            bus.cmd_op = 2'(3 - k); bus.ld_valid = 1'b1; bus.ld_addr = 3'd4; bus.ld_data = 32'd99; #1;
            n_cmp++; if (bus.cmd_ready !== 1'b0 || bus.alu_c !== 2'(k))
                begin n_err++; $display("FAIL b2b_exec%0d: got cr=%b c=%0d want 0 %0d", k, bus.cmd_ready, bus.alu_c, k); end
            @(negedge clk); bus.ld_valid = 1'b0; #1;
            n_cmp++; if (bus.cmd_ready !== 1'b0 || bus.alu_c !== 2'(k) || bus.res_data !== 32'd8)
                begin n_err++; $display("FAIL b2b_wb%0d: got cr=%b c=%0d data=%0d want 0 %0d 8", k, bus.cmd_ready, bus.alu_c, bus.res_data, k); end
            if (bus.res_valid === 1'b1) pulses++;
        end
        @(negedge clk); bus.cmd_valid = 1'b0; bus.dbg_addr = 3'd4; #1;
        n_cmp++; if (pulses != 4) begin n_err++; $display("FAIL b2b_pulses: got %0d want 4", pulses); end
        n_cmp++; if (bus.dbg_data !== 32'd8) begin n_err++; $display("FAIL b2b_ignored_ld: got r4=%0d want 8", bus.dbg_data); end
        bus.dbg_addr = 3'd7; #1;
        n_cmp++; if (bus.dbg_data !== 32'd8) begin n_err++; $display("FAIL b2b_r7: got %0d want 8", bus.dbg_data); end
    endtask

    task automatic test_priority;
        @(negedge clk);
        bus.ld_valid = 1'b1; bus.ld_addr = 3'd2; bus.ld_data = 32'd100;
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b00; bus.cmd_rd = 3'd0; bus.cmd_rs1 = 3'd2; bus.cmd_rs2 = 3'd2; #1;
        n_cmp++; if (bus.cmd_ready !== 1'b0 || bus.ld_ready !== 1'b1)
            begin n_err++; $display("FAIL prio_ready: got cr=%b lr=%b want 0 1", bus.cmd_ready, bus.ld_ready); end
        @(negedge clk); bus.ld_valid = 1'b0; #1;
        n_cmp++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL prio_cmd_next: got %b want 1", bus.cmd_ready); end
        @(negedge clk); bus.cmd_valid = 1'b0; #1;
        n_cmp++; if (bus.alu_a !== 32'd100 || bus.alu_b !== 32'd100)
            begin n_err++; $display("FAIL prio_same_src: got a=%0d b=%0d want 100 100", bus.alu_a, bus.alu_b); end
        @(negedge clk); #1;
        n_cmp++; if (bus.res_valid !== 1'b1 || bus.res_data !== 32'd200 || bus.res_rd !== 3'd0)
            begin n_err++; $display("FAIL prio_wb: got rv=%b data=%0d rd=%0d want 1 200 0", bus.res_valid, bus.res_data, bus.res_rd); end
        @(negedge clk); bus.dbg_addr = 3'd0; #1;
`ifdef ALU_SEQ_R0_ZERO_EN
        n_cmp++; if (bus.dbg_data !== 32'd0) begin n_err++; $display("FAIL prio_r0: got %0d want 0", bus.dbg_data); end
`else
        n_cmp++; if (bus.dbg_data !== 32'd200) begin n_err++; $display("FAIL prio_r0: got %0d want 200", bus.dbg_data); end
`endif
    endtask

    task automatic test_chain;
        preload(3'd6, 32'd10);
        preload(3'd7, 32'd5);
        run_cmd(2'b00, 3'd6, 3'd6, 3'd7, r_data, r_rd, r_a, r_b, r_lat);
        n_cmp++; if (r_data !== 32'd15 || r_lat != 2)
            begin n_err++; $display("FAIL chain_first: got data=%0d lat=%0d want 15 2", r_data, r_lat); end
        run_cmd(2'b00, 3'd6, 3'd6, 3'd7, r_data, r_rd, r_a, r_b, r_lat);
        n_cmp++; if (r_data !== 32'd20 || r_rd !== 3'd6 || r_a !== 32'd15)
            begin n_err++; $display("FAIL chain_second: got data=%0d rd=%0d a=%0d want 20 6 15", r_data, r_rd, r_a); end
        @(negedge clk); bus.dbg_addr = 3'd6; #1;
        n_cmp++; if (bus.dbg_data !== 32'd20) begin n_err++; $display("FAIL chain_r6: got %0d want 20", bus.dbg_data); end
    endtask

    task automatic test_reset_abort;
        int seen;
        seen = 0;
        preload(3'd1, 32'd3);
        preload(3'd2, 32'd4);
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_op = 2'b00; bus.cmd_rd = 3'd3; bus.cmd_rs1 = 3'd1; bus.cmd_rs2 = 3'd2; #1;
        @(negedge clk); bus.cmd_valid = 1'b0; rst_n = 1'b0; #1;
        n_cmp++; if (bus.ld_ready !== 1'b1 || bus.alu_a !== '0)
            begin n_err++; $display("FAIL abort_exec_state: got lr=%b a=%0d want 1 0", bus.ld_ready, bus.alu_a); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); if (i == 1) rst_n = 1'b1; #1;
            if (bus.res_valid === 1'b1) seen++;
        end
        bus.dbg_addr = 3'd3; #1;
        n_cmp++; if (seen != 0) begin n_err++; $display("FAIL abort_exec_res_valid: got %0d pulses want 0", seen); end
        n_cmp++; if (bus.dbg_data !== '0) begin n_err++; $display("FAIL abort_exec_r3: got %0d want 0", bus.dbg_data); end
        preload(3'd1, 32'd3);
        preload(3'd2, 32'd4);
        run_cmd(2'b00, 3'd5, 3'd1, 3'd2, r_data, r_rd, r_a, r_b, r_lat);
        rst_n = 1'b0; #1;
        n_cmp++; if (bus.res_valid !== 1'b0 || bus.cmd_ready !== 1'b1)
            begin n_err++; $display("FAIL abort_wb_state: got rv=%b cr=%b want 0 1", bus.res_valid, bus.cmd_ready); end
        @(negedge clk); rst_n = 1'b1; bus.dbg_addr = 3'd5; #1;
        n_cmp++; if (bus.dbg_data !== '0) begin n_err++; $display("FAIL abort_wb_r5: got %0d want 0", bus.dbg_data); end
    endtask

    task automatic test_r0_zero;
`ifdef ALU_SEQ_R0_ZERO_EN
        preload(3'd0, 32'd9);
        run_cmd(2'b00, 3'd1, 3'd0, 3'd0, r_data, r_rd, r_a, r_b, r_lat);
        n_cmp++; if (r_a !== '0 || r_b !== '0 || r_data !== '0)
            begin n_err++; $display("FAIL r0_zero: got a=%0d b=%0d data=%0d want 0 0 0", r_a, r_b, r_data); end
`else
        preload(3'd0, 32'd9);
        run_cmd(2'b00, 3'd1, 3'd0, 3'd0, r_data, r_rd, r_a, r_b, r_lat);
        n_cmp++; if (r_a !== 32'd9 || r_b !== 32'd9 || r_data !== 32'd18)
            begin n_err++; $display("FAIL r0_plain: got a=%0d b=%0d data=%0d want 9 9 18", r_a, r_b, r_data); end
`endif
        @(negedge clk);
    endtask

    initial begin
        bus.ld_valid = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
        bus.cmd_valid = 1'b0; bus.cmd_op = 2'b00; bus.cmd_rd = '0; bus.cmd_rs1 = '0; bus.cmd_rs2 = '0;
        bus.dbg_addr = '0;
        test_reset;
        test_basic;
        test_back_to_back;
        test_priority;
        test_chain;
        test_reset_abort;
        test_r0_zero;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
- REQ-001: Parameter DATA_W, default 32, operand/result width in bits.
- REQ-002: Parameter NREGS, default 8, register-file depth; address width AW = log2(NREGS).
- REQ-003: clk  input  1  single clock; all state updates on rising edge.
- REQ-004: rst_n  input  1  reset, asynchronous, active-low.
- REQ-005: ld_valid  input  1; ld_addr  input  AW; ld_data  input  DATA_W  register preload request.
- REQ-006: ld_ready  output  1  preload accepted this cycle.
- REQ-007: cmd_valid  input  1; cmd_op  input  2; cmd_rd, cmd_rs1, cmd_rs2  input  AW  operation request.
- REQ-008: cmd_ready  output  1  command accepted this cycle.
- REQ-009: alu_a, alu_b  output  DATA_W; alu_c  output  2  operands and op code driven to the downstream ALU.
- REQ-010: alu_out  input  DATA_W  combinational ALU result.
- REQ-011: res_valid  output  1; res_rd  output  AW; res_data  output  DATA_W  writeback notification.
- REQ-012: dbg_addr  input  AW; dbg_data  output  DATA_W  combinational register-file read.

Function
- REQ-013: FSM states SHALL be IDLE, EXEC and WB; the reset state SHALL be IDLE.
- REQ-014: ld_ready SHALL equal (state==IDLE); cmd_ready SHALL equal (state==IDLE && !ld_valid), so preload has priority over a command.
- REQ-015: On ld_valid&&ld_ready, rf[ld_addr] SHALL take ld_data at the edge; the state SHALL remain IDLE.
- REQ-016: On cmd_valid&&cmd_ready, the block SHALL latch rf[cmd_rs1] into alu_a, rf[cmd_rs2] into alu_b, cmd_op into alu_c and cmd_rd into an internal rd register, then go to EXEC.
- REQ-017: rs1==rs2 SHALL drive the same value on alu_a and alu_b.
- REQ-018: In EXEC the block SHALL capture alu_out into res_data and go to WB; alu_a/alu_b/alu_c SHALL be held stable from the accept edge until leaving WB.
- REQ-019: In WB, res_valid SHALL be 1 for exactly one cycle, and res_rd SHALL equal the latched rd; at the WB edge rf[rd] SHALL take res_data and the state SHALL return to IDLE.
- REQ-020: Latency: command accepted in cycle N, res_valid high in cycle N+2; peak throughput SHALL be one command per 3 cycles.
- REQ-021: A command accepted directly after WB SHALL read the value written back (no stale read); rd==rs1 or rd==rs2 SHALL be legal.
- REQ-022: cmd_valid and ld_valid outside IDLE SHALL be ignored without side effects.
- REQ-023: res_data and alu_* SHALL keep their last values in IDLE; res_valid SHALL be 0 outside WB.

Reset
- REQ-024: rst_n low SHALL immediately force the state to IDLE, all rf entries to 0, alu_a/alu_b/res_data to 0, alu_c/res_rd to 0 and res_valid to 0.
- REQ-025: Reset asserted in EXEC or WB SHALL abort the operation; no register-file write SHALL occur.

Configuration
- REQ-026: With ALU_SEQ_R0_ZERO_EN defined, rf[0] SHALL read as 0 always, and preloads/writebacks to address 0 SHALL be discarded; res_valid SHALL still pulse, with res_data equal to alu_out.
- REQ-027: Without ALU_SEQ_R0_ZERO_EN, address 0 SHALL be an ordinary register.

Structure
- REQ-028: Package alu_pkg SHALL hold DATA_W/NREGS defaults, the 2-bit op typedef and the FSM state enum.
- REQ-029: The register file SHALL be a sub-module alu_regfile (two read ports, one write port, write arbitration done in alu_sequencer).

Verification (bench stub ALU: alu_out = alu_a + alu_b)
- REQ-030: Preload r1=5, r2=6, cmd op=00 rd=3 rs1=1 rs2=2 -> alu_a=5, alu_b=6, alu_c=00; res_valid in cycle N+2 with res_data=11, res_rd=3; dbg r3 then reads 11.
- REQ-031: r4=8, r5=0, op 00..11 issued back-to-back -> cmd_ready low for 2 cycles after each accept; alu_c steps 00,01,10,11; four res_valid pulses.
- REQ-032: ld_valid and cmd_valid both high in IDLE -> preload taken, cmd_ready=0; command accepted next cycle.
- REQ-033: r6=10, r7=5, cmd rd=6 rs1=6 rs2=7, then rd=6 rs1=6 rs2=7 again -> res_data 15, then 20.
- REQ-034: rst_n pulsed low during EXEC -> res_valid never asserts; the target register still reads 0; the state is IDLE.
- REQ-035: With ALU_SEQ_R0_ZERO_EN, preload r0=9 and then cmd rd=1 rs1=0 rs2=0 -> alu_a=0, alu_b=0, res_data=0.
